// File: rtl/bounce_sprites.sv
// bounce_sprites
//   Animates N axis-aligned squares that bounce inside the active area, and
//   reports which square is topmost at each pixel.
//   All positions are updated once per frame by a small FSM that handles one
//   square per clock. This happens during blanking, so no frame is drawn with
//   a mix of old and new positions.
//
// Ports
//   clk_pix  pixel clock
//   rst_n    asynchronous active-low reset
//   frame    one-cycle pulse at the start of vertical blanking
//   pause    ignore frame pulses (freeze motion)
//   spd      per-square speed, square i uses spd[i*4 +: 4] (pixels/frame)
//   sx, sy   current screen coordinate
//   de       data enable
//   busy     high while the update FSM runs (exactly N cycles)
//   hit      hit[i] set when square i bounced in its most recent update
//   pix_id   0 = no square, i+1 = square i topmost (2 cycles after sx/sy/de)
//   pix_de   de delayed to line up with pix_id
module bounce_sprites #(
  parameter int                 CORDW = 10,
  parameter int                 N     = 4,
  parameter int                 H_RES = 640,
  parameter int                 V_RES = 480,
  parameter logic [N*CORDW-1:0] SIZES = {10'd160, 10'd128, 10'd96, 10'd64},
  parameter int                 IDW   = 4
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             frame,
  input  logic             pause,
  input  logic [N*4-1:0]   spd,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  output logic             busy,
  output logic [N-1:0]     hit,
  output logic [IDW-1:0]   pix_id,
  output logic             pix_de
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // One extra bit so that sums such as size+speed or x+size never wrap.
  localparam int CW = CORDW + 1;

  // Reject parameter sets that could push a square off screen.
  if (N < 1 || N > 15 || (2 ** IDW) <= N) begin : g_bad_n
    $error("bounce_sprites: N must be 1..15 and 2**IDW must exceed N");
  end
  for (genvar g = 0; g < N; g++) begin : g_chk
    if (int'(SIZES[g*CORDW +: CORDW]) + 15 >= V_RES ||
        g * 32 + int'(SIZES[g*CORDW +: CORDW]) > H_RES ||
        g * 24 + int'(SIZES[g*CORDW +: CORDW]) > V_RES) begin : g_bad_size
      $error("bounce_sprites: square size or initial position out of bounds");
    end
  end

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    index;
  logic             last;

  logic [CORDW-1:0] pos_x [N];
  logic [CORDW-1:0] pos_y [N];
  logic             dir_x [N];
  logic             dir_y [N];

  logic [CW-1:0]    cur_x, cur_y, cur_s, cur_sz, lim_x, lim_y, nxt_x, nxt_y;
  logic             nxt_dx, nxt_dy, edge_x, edge_y;

  logic [N-1:0]     draw, draw_q;
  logic             de_q;
  logic [IDW-1:0]   top_id;

  assign last = (index == IW'(N - 1));

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE:    if (frame && !pause) state_next = UPDATE;
      UPDATE: begin
        busy = 1'b1;
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bounce rules for the square selected by index. The right/bottom test
  // comes first so that a square hugging the far edge always turns back.
  always_comb begin
    cur_s  = CW'(spd[int'(index)*4 +: 4]);
    cur_sz = CW'(SIZES[int'(index)*CORDW +: CORDW]);
    cur_x  = {1'b0, pos_x[index]};
    cur_y  = {1'b0, pos_y[index]};
    lim_x  = CW'(H_RES) - (cur_sz + cur_s);
    lim_y  = CW'(V_RES) - (cur_sz + cur_s);
    nxt_dx = dir_x[index];
    nxt_dy = dir_y[index];
    edge_x = 1'b0;
    edge_y = 1'b0;

    if (cur_x >= lim_x) begin
      nxt_dx = 1'b1;
      edge_x = 1'b1;
      nxt_x  = cur_x - cur_s;
    end else if (cur_x < cur_s) begin
      nxt_dx = 1'b0;
      edge_x = 1'b1;
      nxt_x  = cur_x + cur_s;
    end else begin
      nxt_x  = dir_x[index] ? cur_x - cur_s : cur_x + cur_s;
    end

    if (cur_y >= lim_y) begin
      nxt_dy = 1'b1;
      edge_y = 1'b1;
      nxt_y  = cur_y - cur_s;
    end else if (cur_y < cur_s) begin
      nxt_dy = 1'b0;
      edge_y = 1'b1;
      nxt_y  = cur_y + cur_s;
    end else begin
      nxt_y  = dir_y[index] ? cur_y - cur_s : cur_y + cur_s;
    end
  end

  // index sits at 0 whenever the FSM is idle, so every update starts with
  // square 0 without a separate load.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
      hit   <= '0;
      for (int i = 0; i < N; i++) begin
        pos_x[i] <= CORDW'(i * 32);
        pos_y[i] <= CORDW'(i * 24);
        dir_x[i] <= 1'b0;
        dir_y[i] <= 1'b0;
      end
    end else if (state == UPDATE) begin
      index        <= last ? '0 : index + 1'b1;
      pos_x[index] <= nxt_x[CORDW-1:0];
      pos_y[index] <= nxt_y[CORDW-1:0];
      dir_x[index] <= nxt_dx;
      dir_y[index] <= nxt_dy;
      hit[index]   <= edge_x | edge_y;
    end
  end

  always_comb begin
    draw = '0;
    for (int i = 0; i < N; i++) begin
      draw[i] = ({1'b0, sx} >= {1'b0, pos_x[i]}) &&
                ({1'b0, sx} <  ({1'b0, pos_x[i]} + CW'(SIZES[i*CORDW +: CORDW]))) &&
                ({1'b0, sy} >= {1'b0, pos_y[i]}) &&
                ({1'b0, sy} <  ({1'b0, pos_y[i]} + CW'(SIZES[i*CORDW +: CORDW])));
    end
  end

  // Scan from the highest index down so the lowest drawn index wins.
  always_comb begin
    top_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (draw_q[i]) top_id = IDW'(i + 1);
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      draw_q <= '0;
      de_q   <= 1'b0;
      pix_id <= '0;
      pix_de <= 1'b0;
    end else begin
      draw_q <= draw;
      de_q   <= de;
      pix_id <= de_q ? top_id : '0;
      pix_de <= de_q;
    end
  end

endmodule

// File: tb/tb_bounce_sprites.sv
// tb_bounce_sprites
//   Self-checking bench for bounce_sprites. A behavioural model of all
//   squares predicts pix_id for probed pixels; predictions go into a
//   scoreboard queue and are compared when the DUT output is due.
module tb_bounce_sprites;

  localparam int CORDW = 10;
  localparam int N     = 4;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int IDW   = 4;
  localparam logic [N*CORDW-1:0] SIZES = {10'd160, 10'd128, 10'd96, 10'd64};

  logic             clk_pix = 1'b0;
  logic             rst_n;
  logic             frame;
  logic             pause;
  logic [N*4-1:0]   spd;
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             de;
  logic             busy;
  logic [N-1:0]     hit;
  logic [IDW-1:0]   pix_id;
  logic             pix_de;

  bounce_sprites #(
    .CORDW(CORDW), .N(N), .H_RES(H_RES), .V_RES(V_RES), .SIZES(SIZES), .IDW(IDW)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .pause(pause), .spd(spd),
    .sx(sx), .sy(sy), .de(de), .busy(busy), .hit(hit), .pix_id(pix_id),
    .pix_de(pix_de)
  );

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc++;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the squares.
  int           sz  [N] = '{64, 96, 128, 160};
  int           mx  [N];
  int           my  [N];
  bit           mdx [N];
  bit           mdy [N];
  logic [N-1:0] mhit;

  typedef struct {
    int             due;
    logic [IDW-1:0] id;
    logic           de;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = i * 32;
      my[i]  = i * 24;
      mdx[i] = 0;
      mdy[i] = 0;
    end
    mhit = '0;
  endfunction

  function automatic void step_axis(inout int p, inout bit d, input int s,
                                    input int size, input int res, output bit e);
    if (p >= res - (size + s)) begin
      d = 1; p = p - s; e = 1;
    end else if (p < s) begin
      d = 0; p = p + s; e = 1;
    end else begin
      e = 0;
      p = d ? p - s : p + s;
    end
  endfunction

  function automatic void model_update(input logic [N*4-1:0] sv);
    bit ex, ey;
    int s;
    for (int i = 0; i < N; i++) begin
      s = int'(sv[i*4 +: 4]);
      step_axis(mx[i], mdx[i], s, sz[i], H_RES, ex);
      step_axis(my[i], mdy[i], s, sz[i], V_RES, ey);
      mhit[i] = ex | ey;
    end
  endfunction

  function automatic int exp_id(input int x, input int y);
    for (int i = 0; i < N; i++) begin
      if (x >= mx[i] && x < mx[i] + sz[i] && y >= my[i] && y < my[i] + sz[i])
        return i + 1;
    end
    return 0;
  endfunction

  function automatic int clampc(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  // Scoreboard consumer: each prediction is due two clocks after its probe.
  always @(negedge clk_pix) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      checkOutput("pix_id", 32'(pix_id), 32'(mon_e.id));
      checkOutput("pix_de", 32'(pix_de), 32'(mon_e.de));
    end
  end

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic applyStimulus(input int x, input int y, input logic d);
    exp_t e;
    sx = CORDW'(x);
    sy = CORDW'(y);
    de = d;
    e.due = cyc + 2;
    e.id  = d ? IDW'(exp_id(x, y)) : '0;
    e.de  = d;
    sb.push_back(e);
    step();
  endtask

  task automatic drain();
    de = 1'b0;
    repeat (3) step();
  endtask

  // Probe corners and just-outside pixels of every square.
  task automatic probe_all();
    for (int i = 0; i < N; i++) begin
      applyStimulus(clampc(mx[i]),             clampc(my[i]),             1'b1);
      applyStimulus(clampc(mx[i] - 1),         clampc(my[i]),             1'b1);
      applyStimulus(clampc(mx[i]),             clampc(my[i] - 1),         1'b1);
      applyStimulus(clampc(mx[i] + sz[i] - 1), clampc(my[i] + sz[i] - 1), 1'b1);
      applyStimulus(clampc(mx[i] + sz[i]),     clampc(my[i] + sz[i] - 1), 1'b1);
      applyStimulus(clampc(mx[i] + sz[i] - 1), clampc(my[i] + sz[i]),     1'b1);
    end
    applyStimulus(clampc(mx[0]), clampc(my[0]), 1'b0);
    drain();
  endtask

  // One frame pulse, optionally followed by a second pulse while busy.
  task automatic run_frame(input logic [3:0] s, input bit extra);
    int busy_cnt;
    spd   = {N{s}};
    frame = 1'b1;
    step();
    frame    = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 3 * N + 3; k++) begin
      if (busy) busy_cnt++;
      frame = (extra && k == 1);
      step();
    end
    frame = 1'b0;
    if (!pause) model_update(spd);
    checkOutput("busy_cycles", 32'(busy_cnt), pause ? 32'd0 : 32'(N));
    checkOutput("hit", 32'(hit), 32'(mhit));
    probe_all();
  endtask

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    frame = 1'b0;
    pause = 1'b0;
    spd   = {N{4'd3}};
    sx    = '0;
    sy    = '0;
    de    = 1'b0;
    model_reset();
    repeat (3) step();
    checkOutput("rst_busy",   32'(busy),   32'd0);
    checkOutput("rst_hit",    32'(hit),    32'd0);
    checkOutput("rst_pix_id", 32'(pix_id), 32'd0);
    checkOutput("rst_pix_de", 32'(pix_de), 32'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] overlap priority at reset positions");
    applyStimulus(40, 30, 1'b1);
    applyStimulus(40, 30, 1'b0);
    applyStimulus(90, 30, 1'b1);
    applyStimulus(600, 400, 1'b1);
    drain();
    probe_all();

    $display("[TB] first frame, speed 3");
    run_frame(4'd3, 1'b0);

    $display("[TB] frame pulse while busy");
    run_frame(4'd3, 1'b1);

    $display("[TB] paused frames");
    pause = 1'b1;
    repeat (3) run_frame(4'd3, 1'b0);
    pause = 1'b0;

    $display("[TB] reset during update");
    spd   = {N{4'd3}};
    frame = 1'b1;
    step();
    frame = 1'b0;
    step();
    checkOutput("busy_pre_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy",   32'(busy),   32'd0);
    checkOutput("mid_rst_hit",    32'(hit),    32'd0);
    checkOutput("mid_rst_pix_id", 32'(pix_id), 32'd0);
    checkOutput("mid_rst_pix_de", 32'(pix_de), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    model_reset();
    probe_all();

    $display("[TB] walk square 0 into the right edge and back to the left");
    run_frame(4'd4, 1'b0);
    repeat (38) run_frame(4'd15, 1'b0);
    run_frame(4'd3, 1'b0);
    repeat (37) run_frame(4'd15, 1'b0);
    run_frame(4'd14, 1'b0);
    run_frame(4'd3, 1'b0);
    run_frame(4'd0, 1'b0);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
